// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and the illegal-code test,
// used by the ALU decoder and the execute pipeline.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic illegal;
  } alu_flags_t;

  // Codes 110 and 111 have no operation assigned.
  function automatic logic is_illegal_op(input logic [2:0] code);
    return code[2] & code[1];
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational ALU (add/sub/and/or/xor/signed slt) with zero and illegal flags.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing pipeline owns all flow control.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  logic slt_lt;

  assign slt_lt = $signed(a) < $signed(b);

  always_comb begin
    result  = '0;
    illegal = is_illegal_op(op);
    case (alu_op_e'(op))
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt_lt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_pipe.sv
// Purpose: two-stage ALU execute pipeline (S1 operand register, S2 result register).
// Latency: result valid two cycles after acceptance when not stalled.
// Backpressure: valid/ready; in_ready = !S1 valid || S2 advances, full throughput with out_ready high.
module alu_exec_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Illegal
);

  logic             s1_vld;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_vld;
  logic [WIDTH-1:0] s2_res;
  alu_flags_t       s2_flags;

  logic             s2_adv;
  logic             s1_take;

  logic [WIDTH-1:0] core_res;
  logic             core_zero;
  logic             core_ill;

  assign s2_adv   = !s2_vld || out_ready;
  assign in_ready = !s1_vld || s2_adv;
  assign s1_take  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
    end else if (in_ready) begin
      s1_vld <= in_valid;
    end
  end

  // Operand registers carry no reset: their contents only matter behind s1_vld.
  always_ff @(posedge clk) begin
    if (s1_take) begin
      s1_op <= ALUControl;
      s1_a  <= SrcA;
      s1_b  <= SrcB;
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (core_res),
    .zero   (core_zero),
    .illegal(core_ill)
  );

  // S2 only reloads when a real operation moves in, so a stalled result holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld   <= 1'b0;
      s2_res   <= '0;
      s2_flags <= '0;
    end else if (s2_adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_res           <= core_res;
        s2_flags.zero    <= core_zero;
        s2_flags.illegal <= core_ill;
      end
    end
  end

  assign out_valid = s2_vld;
  assign ALUResult = s2_res;
  assign Zero      = s2_flags.zero;
  assign Illegal   = s2_flags.illegal;

endmodule

// File: doc/alu_exec_pipe.md
ALU_EXEC_PIPE -- requirements
Module: alu_exec_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, upstream operation valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operation this cycle.
REQ-006 SHALL have port ALUControl, input, 3, operation code from the ALU decoder.
REQ-007 SHALL have port SrcA, input, WIDTH, first operand.
REQ-008 SHALL have port SrcB, input, WIDTH, second operand.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port ALUResult, output, WIDTH, operation result.
REQ-012 SHALL have port Zero, output, 1, set when ALUResult is all zeros.
REQ-013 SHALL have port Illegal, output, 1, set when the originating ALUControl was 110 or 111.

Function
REQ-014 SHALL decode ALUControl as follows: 000 add; 001 sub (A-B); 010 and; 011 or; 100 xor; 101 signed slt, which returns 1 or 0 zero-extended.
REQ-015 SHALL compute add and sub modulo 2^WIDTH, with carry discarded.
REQ-016 SHALL produce ALUResult=0 and Illegal=1 for codes 110 and 111; Illegal SHALL be 0 for all other codes.
REQ-017 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-018 SHALL be a 2-stage pipeline: S1 registers the operands and code, and S2 registers ALUResult, Zero and Illegal computed from S1.
REQ-019 SHALL present a result accepted at cycle N with out_valid high at cycle N+2 when the pipeline does not stall.
REQ-020 SHALL sustain one operation per cycle while out_ready is held high.
REQ-021 SHALL advance S2 when !S2.valid || out_ready.
REQ-022 SHALL advance S1 into S2 when S1.valid and S2 advances.
REQ-023 SHALL drive in_ready = !S1.valid || S2 advances, combinationally from out_ready and the valid bits.
REQ-024 SHALL hold ALUResult, Zero and Illegal stable while out_valid && !out_ready.
REQ-025 SHALL preserve order and never drop or duplicate an operation under any out_ready pattern.
REQ-026 SHALL, when S2 is full and stalled, hold S1 if it is occupied and deassert in_ready when S1 is full.
REQ-027 SHALL, on a simultaneous S2 drain and new input, move S1 to S2 and load S1 from the input in the same cycle.
REQ-028 SHALL ignore ALUControl, SrcA and SrcB when in_valid=0.

Reset
REQ-029 SHALL clear S1.valid and S2.valid when reset is high at a clock edge, so out_valid=0 in the following cycle.
REQ-030 SHALL clear ALUResult, Zero and Illegal to 0 on reset; data registers need no other reset.
REQ-031 SHALL discard all in-flight operations when reset occurs mid-operation, with no output produced for them.
REQ-032 SHALL hold in_ready=1 in the first cycle after reset.

Structure
REQ-033 SHALL take the ALU operation encodings (the enum for 000-101) and the illegal-code test from the shared package alu_pkg, which the ALU decoder also uses.
REQ-034 SHALL place the combinational operation in one sub-module, alu_core (inputs op, a, b; outputs result, zero, illegal), instantiated between S1 and S2.

Verification
REQ-035 SHALL cover: reset, then op 000 with A=5, B=7 and out_ready=1 -> two cycles later out_valid=1, ALUResult=12, Zero=0.
REQ-036 SHALL cover: op 001 with A=9, B=9 -> ALUResult=0, Zero=1; op 101 with A=0xFFFFFFFF, B=1 -> ALUResult=1; op 101 with A=1, B=0xFFFFFFFF -> ALUResult=0.
REQ-037 SHALL cover: op 000 with A=0xFFFFFFFF, B=1 -> ALUResult=0, Zero=1; op 110 -> ALUResult=0, Illegal=1.
REQ-038 SHALL cover: four back-to-back ops with out_ready=0 -> in_ready falls after two accepts; raising out_ready -> results emerge in order, one per cycle, none lost.
REQ-039 SHALL cover: reset asserted with both stages full -> out_valid=0 next cycle, in_ready=1, and the old results are never emitted.
REQ-040 SHALL cover: random valid/ready stimulus -> scoreboard matches the reference model for every op and outputs stay stable while stalled.
